// File: rtl/expr_gen.sv
// expr_gen: serializes one latched expression of the form digit (op digit)*
// into an ASCII valid/ready byte stream. Digits go out as '0'..'9' and
// operators as '+' or '*'. A start request is checked before anything is
// latched; a malformed request produces a single err pulse and is dropped.
module expr_gen #(
  parameter int MAX_TERMS = 8,
  parameter int CW        = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CW-1:0]          n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int IW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DIG,
    OP
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          n_lat;
  logic [4*MAX_TERMS-1:0] digits_lat;
  logic [MAX_TERMS-1:0]   ops_lat;
  logic [3:0]             cur_digit;
  logic                   req_bad;
  logic                   accept;
  logic                   reject;
  logic                   is_last;

  // Decide whether a start request describes a well-formed expression:
  // term count within 1..MAX_TERMS and every used term a BCD digit.
  always_comb begin
    req_bad = 1'b0;
    if (n_terms == '0 || n_terms > CW'(MAX_TERMS)) begin
      req_bad = 1'b1;
    end
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (CW'(i) < n_terms && digits[4*i +: 4] > 4'd9) begin
        req_bad = 1'b1;
      end
    end
  end

  // Requests only count in IDLE, so a start while busy is silently ignored.
  assign accept    = (state == IDLE) && start && !req_bad;
  assign reject    = (state == IDLE) && start && req_bad;
  assign cur_digit = digits_lat[{idx, 2'b00} +: 4];
  assign is_last   = (CW'(idx) == n_lat - CW'(1));
  assign busy      = (state != IDLE);

  // Next-state and byte presentation; outputs depend only on state and
  // latched data, so they stay stable while the sink stalls.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DIG;
        end
      end
      DIG: begin
        out_valid = 1'b1;
        out_data  = 8'd48 + {4'd0, cur_digit};
        out_last  = is_last;
        if (out_ready) begin
          state_nxt = is_last ? IDLE : OP;
        end
      end
      OP: begin
        out_valid = 1'b1;
        out_data  = ops_lat[idx] ? 8'd42 : 8'd43;
        if (out_ready) begin
          state_nxt = DIG;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus the expression snapshot taken when a request is accepted;
  // the term index only advances after an operator byte is consumed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      idx        <= '0;
      n_lat      <= '0;
      digits_lat <= '0;
      ops_lat    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx        <= '0;
        n_lat      <= n_terms;
        digits_lat <= digits;
        ops_lat    <= {1'b0, ops};
      end else if (state == OP && out_ready) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // One-cycle status pulses: done after the final digit is taken, err after a rejected request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (state == DIG) && out_ready && is_last;
      err  <= reject;
    end
  end

endmodule
